// File: rtl/cpu_defs.sv
// cpu_defs: shared encodings and decode helpers for the control sequencer
package cpu_defs;
  localparam int INSTR_W = 15;
  localparam int CLASS_BIT = 6;
  localparam int DST_BIT = 5;
  localparam int SRC_BIT = 4;
  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_e;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_op_e;
  typedef enum logic [2:0] {
    C_JMP  = 3'd0,
    C_JEQ  = 3'd1,
    C_JNE  = 3'd2,
    C_JGT  = 3'd3,
    C_JLT  = 3'd4,
    C_JCR  = 3'd5,
    C_NOP  = 3'd6,
    C_HALT = 3'd7
  } ctrl_op_e;
  function automatic logic branch_taken(input logic [2:0] sub, input logic z, input logic n, input logic c);
    return sub == C_JMP ? 1'b1 :
           sub == C_JEQ ? z :
           sub == C_JNE ? !z :
           sub == C_JGT ? (!z && !n) :
           sub == C_JLT ? n :
           sub == C_JCR ? c : 1'b0;
  endfunction
endpackage

// File: rtl/pc_counter.sv
// pc_counter: program counter with load-over-increment priority, wraps modulo 2^PC_WIDTH
module pc_counter #(
  parameter int PC_WIDTH = 8,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_val,
  output logic [PC_WIDTH-1:0] pc
);
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  always_comb pc_d = load ? load_val : inc ? pc_q + 1'b1 : pc_q;
  always_ff @(posedge clk)
    if (reset) pc_q <= PC_WIDTH'(RESET_PC);
    else pc_q <= pc_d;
  assign pc = pc_q;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/exec/wb control unit for the accumulator datapath
module control_sequencer
  import cpu_defs::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int DATA_WIDTH = 8,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INSTR_W-1:0]    instr,
  input  logic                  im_valid,
  input  logic                  alu_z,
  input  logic                  alu_n,
  input  logic                  alu_c,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [DATA_WIDTH-1:0] literal,
  output logic                  sel_b,
  output logic [2:0]            alu_op,
  output logic                  load_a,
  output logic                  load_b,
  output logic                  halted,
  output logic [1:0]            state
);
  state_e                state_q, state_d;
  logic [INSTR_W-1:0]    ir_q, ir_d;
  logic [DATA_WIDTH-1:0] lit_q, lit_d;
  logic                  sel_b_q, sel_b_d;
  logic [2:0]            alu_op_q, alu_op_d;
  logic [2:0]            flags_q, flags_d;
  logic                  halted_q, halted_d;
  logic                  pc_inc, pc_load, is_ctrl, taken;
  logic [2:0]            sub;
  logic                  unused_ir;
  assign is_ctrl = ir_q[8+CLASS_BIT];
  assign sub = ir_q[10:8];
  // opcode[3] and the IR literal copy carry no control meaning
  assign unused_ir = ^{ir_q[11], ir_q[7:0]};
  // conditions look only at flags latched by the last ALU instruction
  assign taken = branch_taken(sub, flags_q[2], flags_q[1], flags_q[0]);
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    lit_d = lit_q;
    sel_b_d = sel_b_q;
    alu_op_d = alu_op_q;
    flags_d = flags_q;
    halted_d = halted_q;
    pc_inc = 1'b0;
    pc_load = 1'b0;
    if (!halted_q)
      case (state_q)
        S_FETCH:
          if (im_valid) begin
            ir_d = instr;
            lit_d = DATA_WIDTH'(instr[7:0]);
            state_d = S_DECODE;
          end
        S_DECODE: begin
          sel_b_d = is_ctrl ? sel_b_q : ir_q[8+SRC_BIT];
          alu_op_d = is_ctrl ? alu_op_q : sub;
          state_d = S_EXEC;
        end
        S_EXEC:
          if (!is_ctrl) begin
            flags_d = {alu_z, alu_n, alu_c};
            state_d = S_WB;
          end else if (sub == C_HALT) begin
            halted_d = 1'b1;
          end else begin
            pc_load = taken;
            pc_inc = !taken;
            state_d = S_FETCH;
          end
        S_WB: begin
          pc_inc = 1'b1;
          state_d = S_FETCH;
        end
      endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= S_FETCH;
      ir_q <= '0;
      lit_q <= '0;
      sel_b_q <= 1'b0;
      alu_op_q <= ALU_ADD;
      flags_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      lit_q <= lit_d;
      sel_b_q <= sel_b_d;
      alu_op_q <= alu_op_d;
      flags_q <= flags_d;
      halted_q <= halted_d;
    end
  pc_counter #(.PC_WIDTH(PC_WIDTH), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .reset(reset),
    .inc(pc_inc),
    .load(pc_load),
    .load_val(PC_WIDTH'(lit_q)),
    .pc(pc)
  );
  assign load_a = state_q == S_WB && !ir_q[8+DST_BIT];
  assign load_b = state_q == S_WB && ir_q[8+DST_BIT];
  assign literal = lit_q;
  assign sel_b = sel_b_q;
  assign alu_op = alu_op_q;
  assign halted = halted_q;
  assign state = state_q;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: table-driven scoreboard bench plus hand-written corner sequences
module tb_control_sequencer;
  logic clk = 1'b0, reset, im_valid, alu_z, alu_n, alu_c;
  logic [14:0] instr;
  logic [7:0] pc, literal;
  logic sel_b, load_a, load_b, halted;
  logic [2:0] alu_op;
  logic [1:0] state;
  control_sequencer dut (
    .clk(clk), .reset(reset), .instr(instr), .im_valid(im_valid),
    .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .pc(pc), .literal(literal),
    .sel_b(sel_b), .alu_op(alu_op), .load_a(load_a), .load_b(load_b),
    .halted(halted), .state(state)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [14:0] instr;
    logic z, n, c;
    logic [7:0] pc;
    logic sel;
    logic [2:0] op;
    logic la, lb;
  } vec_t;
  vec_t tbl[17];
  vec_t sb[$];
  vec_t e;
  int total = 0, passes = 0, stray = 0, la_cnt = 0, lb_cnt = 0;
  logic mon_en = 1'b0;
  logic [1:0] prev = 2'd0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [14:0] ins);
    instr = ins;
    im_valid = 1'b1;
  endtask
  always @(negedge clk) begin
    if ((load_a && load_b) || ((load_a || load_b) && state != 2'd3)) stray++;
    if (mon_en) begin
      if (load_a) la_cnt++;
      if (load_b) lb_cnt++;
      if (state == 2'd0 && prev != 2'd0) begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk($sformatf("pc[%h]", e.instr), 32'(pc), 32'(e.pc));
          chk($sformatf("sel_b[%h]", e.instr), 32'(sel_b), 32'(e.sel));
          chk($sformatf("alu_op[%h]", e.instr), 32'(alu_op), 32'(e.op));
          chk($sformatf("load_a_pulses[%h]", e.instr), 32'(la_cnt), 32'(e.la));
          chk($sformatf("load_b_pulses[%h]", e.instr), 32'(lb_cnt), 32'(e.lb));
        end else begin
          total++;
          $display("FAIL unexpected_retire: pc %0h with empty scoreboard", pc);
        end
        la_cnt = 0;
        lb_cnt = 0;
      end
    end
    prev = state;
  end
  initial begin
    //          instr     z  n  c  pc     sel op    la lb
    tbl[0]  = '{15'h0005, 0, 0, 0, 8'h01, 0, 3'd0, 1, 0};
    tbl[1]  = '{15'h3100, 1, 0, 0, 8'h02, 1, 3'd1, 0, 1};
    tbl[2]  = '{15'h4120, 0, 1, 1, 8'h20, 1, 3'd1, 0, 0};
    tbl[3]  = '{15'h2200, 0, 1, 0, 8'h21, 0, 3'd2, 0, 1};
    tbl[4]  = '{15'h4130, 1, 0, 0, 8'h22, 0, 3'd2, 0, 0};
    tbl[5]  = '{15'h4440, 0, 0, 0, 8'h40, 0, 3'd2, 0, 0};
    tbl[6]  = '{15'h1B00, 0, 0, 1, 8'h41, 1, 3'd3, 1, 0};
    tbl[7]  = '{15'h4560, 0, 0, 0, 8'h60, 1, 3'd3, 0, 0};
    tbl[8]  = '{15'h4270, 1, 0, 0, 8'h70, 1, 3'd3, 0, 0};
    tbl[9]  = '{15'h4380, 1, 1, 0, 8'h80, 1, 3'd3, 0, 0};
    tbl[10] = '{15'h7890, 0, 0, 0, 8'h90, 1, 3'd3, 0, 0};
    tbl[11] = '{15'h0C00, 1, 0, 0, 8'h91, 0, 3'd4, 1, 0};
    tbl[12] = '{15'h42AA, 0, 0, 0, 8'h92, 0, 3'd4, 0, 0};
    tbl[13] = '{15'h4346, 0, 0, 0, 8'h93, 0, 3'd4, 0, 0};
    tbl[14] = '{15'h40FF, 0, 0, 0, 8'hFF, 0, 3'd4, 0, 0};
    tbl[15] = '{15'h4600, 0, 0, 0, 8'h00, 0, 3'd4, 0, 0};
    tbl[16] = '{15'h3F01, 0, 0, 0, 8'h01, 1, 3'd7, 0, 1};
    reset = 1'b1;
    alu_z = 1'b0;
    alu_n = 1'b0;
    alu_c = 1'b0;
    issue(15'h3100);
    tick();
    tick();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_literal", 32'(literal), 32'h0);
    chk("rst_sel_b", 32'(sel_b), 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'h0);
    chk("rst_loads", 32'({load_a, load_b}), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    im_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    #1;
    mon_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      sb.push_back(tbl[i]);
      instr = tbl[i].instr;
      alu_z = tbl[i].z;
      alu_n = tbl[i].n;
      alu_c = tbl[i].c;
      im_valid = 1'b1;
      for (int k = 0; k < 12 && sb.size() != 0; k++) begin
        @(negedge clk);
        #1;
      end
      if (sb.size() != 0) begin
        total++;
        $display("FAIL timeout vec %0d: instr %h never retired", i, tbl[i].instr);
        sb.delete();
      end
    end
    im_valid = 1'b0;
    mon_en = 1'b0;
    repeat (5) begin
      tick();
      chk("idle_state", 32'(state), 32'h0);
      chk("idle_pc", 32'(pc), 32'h01);
    end
    issue(15'h405A);
    repeat (3) tick();
    chk("jmp_pc", 32'(pc), 32'h5A);
    issue(15'h4700);
    repeat (3) tick();
    chk("halt_set", 32'(halted), 32'h1);
    issue(15'h4000);
    repeat (20) begin
      tick();
      chk("halt_pc_frozen", 32'(pc), 32'h5A);
      chk("halt_sticky", 32'(halted), 32'h1);
    end
    reset = 1'b1;
    im_valid = 1'b0;
    tick();
    chk("halt_rst_halted", 32'(halted), 32'h0);
    chk("halt_rst_state", 32'(state), 32'h0);
    chk("halt_rst_pc", 32'(pc), 32'h0);
    reset = 1'b0;
    issue(15'h4033);
    repeat (3) tick();
    chk("pre_exec_pc", 32'(pc), 32'h33);
    issue(15'h0005);
    repeat (2) tick();
    chk("in_exec_state", 32'(state), 32'h2);
    reset = 1'b1;
    im_valid = 1'b0;
    tick();
    chk("exec_rst_state", 32'(state), 32'h0);
    chk("exec_rst_pc", 32'(pc), 32'h0);
    chk("exec_rst_loads", 32'({load_a, load_b}), 32'h0);
    chk("exec_rst_halted", 32'(halted), 32'h0);
    reset = 1'b0;
    issue(15'h4033);
    repeat (3) tick();
    issue(15'h3100);
    repeat (3) tick();
    chk("in_wb_state", 32'(state), 32'h3);
    chk("in_wb_loads", 32'({load_a, load_b}), 32'h1);
    reset = 1'b1;
    im_valid = 1'b0;
    tick();
    chk("wb_rst_state", 32'(state), 32'h0);
    chk("wb_rst_pc", 32'(pc), 32'h0);
    chk("wb_rst_loads", 32'({load_a, load_b}), 32'h0);
    chk("wb_rst_sel_op", 32'({sel_b, alu_op}), 32'h0);
    reset = 1'b0;
    tick();
    chk("stray_strobe", 32'(stray), 32'h0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
